// File: rtl/aduna_pkg.sv
// aduna_pkg: shared constants and types for the aduna carry-lookahead adder.
package aduna_pkg;
  localparam int GROUP_W = 4;
  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/aduna_cla4.sv
// aduna_cla4: combinational 4-bit carry-lookahead group with group generate/propagate.
module aduna_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       G,
  output logic       P
);
  logic [3:0] g, p, c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    P = &p;
    cout = G | (P & cin);
    sum = p ^ c;
  end
endmodule

// File: rtl/aduna.sv
// aduna: registered WIDTH-bit adder {c4,s} = x + y + c0 built from 4-bit CLA groups.
// Defining ADUNA_OVERFLOW_FLAG_EN adds the registered signed-overflow output ovf.
module aduna
  import aduna_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c4
`ifdef ADUNA_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int NG = num_groups(WIDTH);
  gp_t [NG-1:0] gp;
  logic [NG:0] gc;
  logic [NG-1:0] co_unused;
  logic [WIDTH-1:0] sum, s_d, s_q;
  logic c4_d, c4_q, vld_d, vld_q;
  assign gc[0] = c0;
  // Groups ripple their carries through group G/P rather than through cout.
  for (genvar i = 0; i < NG; i++) begin : g_grp
    logic gg, pp;
    aduna_cla4 u_cla (
      .a   (x[GROUP_W*i +: GROUP_W]),
      .b   (y[GROUP_W*i +: GROUP_W]),
      .cin (gc[i]),
      .sum (sum[GROUP_W*i +: GROUP_W]),
      .cout(co_unused[i]),
      .G   (gg),
      .P   (pp)
    );
    assign gp[i] = '{g: gg, p: pp};
    assign gc[i+1] = gp[i].g | (gp[i].p & gc[i]);
  end
  always_comb begin
    s_d = in_valid ? sum : s_q;
    c4_d = in_valid ? gc[NG] : c4_q;
    vld_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c4_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c4_q <= c4_d;
      vld_q <= vld_d;
    end
  end
  assign s = s_q;
  assign c4 = c4_q;
  assign out_valid = vld_q;
`ifdef ADUNA_OVERFLOW_FLAG_EN
  logic ovf_d, ovf_q;
  // Carry into the MSB is recovered as sum ^ x ^ y at that bit.
  always_comb ovf_d = in_valid ? (x[WIDTH-1] ^ y[WIDTH-1] ^ sum[WIDTH-1] ^ gc[NG]) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_aduna.sv
// tb_aduna: directed checks of aduna at WIDTH=4 plus a WIDTH=16 sweep (ADUNA_OVERFLOW_FLAG_EN adds ovf checks).
module tb_aduna;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v4 = 1'b0, c04 = 1'b0, vo4, c44;
  logic [3:0] x4 = '0, y4 = '0, s4;
  logic v16 = 1'b0, c016 = 1'b0, vo16, c416;
  logic [15:0] x16 = '0, y16 = '0, s16;
`ifdef ADUNA_OVERFLOW_FLAG_EN
  logic f4, f16;
`endif
  int n = 0;
  int bad = 0;

  aduna #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .x(x4), .y(y4), .c0(c04),
    .out_valid(vo4), .s(s4), .c4(c44)
`ifdef ADUNA_OVERFLOW_FLAG_EN
    , .ovf(f4)
`endif
  );

  aduna #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .x(x16), .y(y16), .c0(c016),
    .out_valid(vo16), .s(s16), .c4(c416)
`ifdef ADUNA_OVERFLOW_FLAG_EN
    , .ovf(f16)
`endif
  );

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    @(negedge clk);
    x4 = a; y4 = b; c04 = c; v4 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    @(negedge clk);
    x16 = a; y16 = b; c016 = c; v16 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n++;
    if ({vo4, c44, s4} !== 6'b0_0_0000) begin
      bad++; $display("FAIL reset4: got %b want %b", {vo4, c44, s4}, 6'b0);
    end
    n++;
    if ({vo16, c416, s16} !== 18'd0) begin
      bad++; $display("FAIL reset16: got %h want %h", {vo16, c416, s16}, 18'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    drive4(4'b1001, 4'b0011, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_0_1100) begin
      bad++; $display("FAIL basic: got %b want %b", {vo4, c44, s4}, 6'b1_0_1100);
    end
    drive4(4'h0, 4'h0, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_0_0000) begin
      bad++; $display("FAIL zero: got %b want %b", {vo4, c44, s4}, 6'b1_0_0000);
    end
  endtask

  task automatic test_carry;
    drive4(4'b1001, 4'b1011, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_0100) begin
      bad++; $display("FAIL carry: got %b want %b", {vo4, c44, s4}, 6'b1_1_0100);
    end
    drive4(4'b1001, 4'b1011, 1'b1, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_0101) begin
      bad++; $display("FAIL carry_cin: got %b want %b", {vo4, c44, s4}, 6'b1_1_0101);
    end
  endtask

  task automatic test_propagate;
    drive4(4'hF, 4'h0, 1'b1, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_0000) begin
      bad++; $display("FAIL propagate: got %b want %b", {vo4, c44, s4}, 6'b1_1_0000);
    end
    drive4(4'hF, 4'hF, 1'b1, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_1111) begin
      bad++; $display("FAIL all_ones: got %b want %b", {vo4, c44, s4}, 6'b1_1_1111);
    end
    drive16(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    n++;
    if ({vo16, c416, s16} !== {2'b11, 16'h0000}) begin
      bad++; $display("FAIL propagate16: got %h want %h", {vo16, c416, s16}, {2'b11, 16'h0000});
    end
    drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    drive4(4'd3, 4'd4, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_0_0111) begin
      bad++; $display("FAIL stream0: got %b want %b", {vo4, c44, s4}, 6'b1_0_0111);
    end
    drive4(4'd8, 4'd8, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_0000) begin
      bad++; $display("FAIL stream1: got %b want %b", {vo4, c44, s4}, 6'b1_1_0000);
    end
    drive4(4'd6, 4'd5, 1'b1, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_0_1100) begin
      bad++; $display("FAIL stream2: got %b want %b", {vo4, c44, s4}, 6'b1_0_1100);
    end
    drive4(4'hF, 4'hF, 1'b1, 1'b0);
    n++;
    if ({vo4, c44, s4} !== 6'b0_0_1100) begin
      bad++; $display("FAIL hold0: got %b want %b", {vo4, c44, s4}, 6'b0_0_1100);
    end
    drive4(4'h7, 4'h2, 1'b0, 1'b0);
    n++;
    if ({vo4, c44, s4} !== 6'b0_0_1100) begin
      bad++; $display("FAIL hold1: got %b want %b", {vo4, c44, s4}, 6'b0_0_1100);
    end
  endtask

  task automatic test_async_reset;
    drive4(4'hA, 4'h9, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b1_1_0011) begin
      bad++; $display("FAIL pre_reset: got %b want %b", {vo4, c44, s4}, 6'b1_1_0011);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n++;
    if ({vo4, c44, s4} !== 6'b0_0_0000) begin
      bad++; $display("FAIL async_reset: got %b want %b", {vo4, c44, s4}, 6'b0);
    end
    drive4(4'd5, 4'd2, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, s4} !== 6'b0_0_0000) begin
      bad++; $display("FAIL reset_discard: got %b want %b", {vo4, c44, s4}, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n++;
    if ({vo4, c44, s4} !== 6'b1_0_0111) begin
      bad++; $display("FAIL post_reset: got %b want %b", {vo4, c44, s4}, 6'b1_0_0111);
    end
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wide_random;
    logic [15:0] a, b;
    logic c;
    logic [17:0] exp;
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      exp = {1'b1, 17'(a) + 17'(b) + 17'(c)};
      drive16(a, b, c, 1'b1);
      n++;
      if ({vo16, c416, s16} !== exp) begin
        bad++; $display("FAIL rand16 %0d: %h+%h+%b got %h want %h", k, a, b, c, {vo16, c416, s16}, exp);
      end
    end
    drive16(16'h0, 16'h0, 1'b0, 1'b0);
  endtask

`ifdef ADUNA_OVERFLOW_FLAG_EN
  task automatic test_ovf;
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    n++;
    if ({vo16, c416, f16, s16} !== {3'b101, 16'h8000}) begin
      bad++; $display("FAIL ovf_pos: got %h want %h", {vo16, c416, f16, s16}, {3'b101, 16'h8000});
    end
    drive16(16'h8000, 16'h8000, 1'b0, 1'b1);
    n++;
    if ({vo16, c416, f16, s16} !== {3'b111, 16'h0000}) begin
      bad++; $display("FAIL ovf_neg: got %h want %h", {vo16, c416, f16, s16}, {3'b111, 16'h0000});
    end
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    n++;
    if ({vo16, c416, f16, s16} !== {3'b110, 16'h0000}) begin
      bad++; $display("FAIL ovf_none: got %h want %h", {vo16, c416, f16, s16}, {3'b110, 16'h0000});
    end
    drive16(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    n++;
    if (f16 !== 1'b0) begin
      bad++; $display("FAIL ovf_hold: got %b want %b", f16, 1'b0);
    end
    drive4(4'h8, 4'h8, 1'b0, 1'b1);
    n++;
    if ({vo4, c44, f4, s4} !== 7'b1_1_1_0000) begin
      bad++; $display("FAIL ovf4: got %b want %b", {vo4, c44, f4, s4}, 7'b1_1_1_0000);
    end
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_propagate;
    test_back_to_back;
    test_async_reset;
    test_wide_random;
`ifdef ADUNA_OVERFLOW_FLAG_EN
    test_ovf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
